// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted conditional branches, resolved oldest-first, driving PHT updates and GHR repair.
// Optional event counters are enabled by defining BRQ_STATS_EN.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_valid,
  input  logic [IDX_W-1:0]           fetch_pc_bits,
  input  logic                       fetch_predict,
  output logic                       fetch_ready,
  output logic [IDX_W-1:0]           pred_index,
  input  logic                       resolve_valid,
  input  logic                       resolve_taken,
  output logic                       pht_write,
  output logic [IDX_W-1:0]           pht_index,
  output logic                       pht_last_branch,
  output logic                       mispredict,
  output logic [IDX_W-1:0]           spec_ghr,
  output logic [IDX_W-1:0]           arch_ghr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic [15:0]                stat_branches,
  output logic [15:0]                stat_mispredicts
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_RUN, S_RECOVER} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   spec_ghr_q, spec_ghr_d, arch_ghr_q, arch_ghr_d;
  logic               pht_write_q, pht_write_d;
  logic [IDX_W-1:0]   pht_index_q, pht_index_d;
  logic               pht_last_q, pht_last_d;
  logic               mispredict_q, mispredict_d;

  logic [IDX_W-1:0]   idx_mem [DEPTH];
  logic               pred_mem [DEPTH];

  logic push, pop, mis, push_eff;
  logic [IDX_W-1:0] head_idx;
  logic             head_pred;

  assign pred_index  = fetch_pc_bits ^ spec_ghr_q;
  assign fetch_ready = (state_q == S_RUN) && (count_q < CNT_W'(DEPTH));
  assign head_idx    = idx_mem[head_q];
  assign head_pred   = pred_mem[head_q];

  assign push     = fetch_valid && fetch_ready;
  assign pop      = (state_q == S_RUN) && resolve_valid && (count_q != '0);
  assign mis      = pop && (resolve_taken != head_pred);
  // A mispredicting pop means this cycle's fetch is on the wrong path, so it is dropped.
  assign push_eff = push && !mis;

  always_comb begin
    state_d      = S_RUN;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    spec_ghr_d   = spec_ghr_q;
    arch_ghr_d   = arch_ghr_q;
    pht_write_d  = pop;
    pht_index_d  = pht_index_q;
    pht_last_d   = pht_last_q;
    mispredict_d = mis;

    if (pop) begin
      pht_index_d = head_idx;
      pht_last_d  = resolve_taken;
      arch_ghr_d  = {arch_ghr_q[IDX_W-2:0], resolve_taken};
    end

    if (mis) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      spec_ghr_d = {arch_ghr_q[IDX_W-2:0], resolve_taken};
      state_d    = S_RECOVER;
    end else begin
      if (push_eff) begin
        tail_d     = tail_q + PTR_W'(1);
        spec_ghr_d = {spec_ghr_q[IDX_W-2:0], fetch_predict};
      end
      if (pop) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_eff) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      spec_ghr_q   <= '0;
      arch_ghr_q   <= '0;
      pht_write_q  <= 1'b0;
      pht_index_q  <= '0;
      pht_last_q   <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      spec_ghr_q   <= spec_ghr_d;
      arch_ghr_q   <= arch_ghr_d;
      pht_write_q  <= pht_write_d;
      pht_index_q  <= pht_index_d;
      pht_last_q   <= pht_last_d;
      mispredict_q <= mispredict_d;
    end
  end

  // Entry storage needs no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (!rst && push_eff) begin
      idx_mem[tail_q]  <= pred_index;
      pred_mem[tail_q] <= fetch_predict;
    end
  end

  assign pht_write       = pht_write_q;
  assign pht_index       = pht_index_q;
  assign pht_last_branch = pht_last_q;
  assign mispredict      = mispredict_q;
  assign spec_ghr        = spec_ghr_q;
  assign arch_ghr        = arch_ghr_q;
  assign count           = count_q;
  assign empty           = (count_q == '0);

`ifdef BRQ_STATS_EN
  logic [15:0] stat_br_q, stat_mis_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      if (pop && stat_br_q != 16'hFFFF) stat_br_q <= stat_br_q + 16'd1;
      if (mis && stat_mis_q != 16'hFFFF) stat_mis_q <= stat_mis_q + 16'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mis_q;
`else
  assign stat_branches    = 16'd0;
  assign stat_mispredicts = 16'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed test of branch_resolve_queue (DEPTH=4, IDX_W=4) with hand-computed expectations.
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [3:0]  fetch_pc_bits;
  logic        fetch_predict;
  logic        fetch_ready;
  logic [3:0]  pred_index;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        pht_write;
  logic [3:0]  pht_index;
  logic        pht_last_branch;
  logic        mispredict;
  logic [3:0]  spec_ghr;
  logic [3:0]  arch_ghr;
  logic [2:0]  count;
  logic        empty;
  logic [15:0] stat_branches;
  logic [15:0] stat_mispredicts;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_queue #(.DEPTH(4), .IDX_W(4)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_pc_bits(fetch_pc_bits), .fetch_predict(fetch_predict),
    .fetch_ready(fetch_ready), .pred_index(pred_index),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .pht_write(pht_write), .pht_index(pht_index), .pht_last_branch(pht_last_branch),
    .mispredict(mispredict), .spec_ghr(spec_ghr), .arch_ghr(arch_ghr),
    .count(count), .empty(empty),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fv, input logic [3:0] pc, input logic fp,
                       input logic rv, input logic rt);
    fetch_valid   = fv;
    fetch_pc_bits = pc;
    fetch_predict = fp;
    resolve_valid = rv;
    resolve_taken = rt;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_spec", 32'(spec_ghr), 0);
    chk("rst_arch", 32'(arch_ghr), 0);
    chk("rst_pht_write", 32'(pht_write), 0);
    chk("rst_pht_index", 32'(pht_index), 0);
    chk("rst_mispredict", 32'(mispredict), 0);
    chk("rst_ready", 32'(fetch_ready), 1);
    chk("rst_stat_br", 32'(stat_branches), 0);

    // First fetch: pc=3 predict=1
    drive(1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
    #1;
    chk("f0_pred_index", 32'(pred_index), 32'h3);
    step();
    chk("f0_spec", 32'(spec_ghr), 32'h1);
    chk("f0_count", 32'(count), 1);

    // Resolve taken: correct prediction
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    step();
    chk("r0_pht_write", 32'(pht_write), 1);
    chk("r0_pht_index", 32'(pht_index), 32'h3);
    chk("r0_pht_last", 32'(pht_last_branch), 1);
    chk("r0_mispredict", 32'(mispredict), 0);
    chk("r0_arch", 32'(arch_ghr), 32'h1);
    chk("r0_count", 32'(count), 0);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("r0_pht_write_drop", 32'(pht_write), 0);

    // Fill the queue: indices 4,5,1,5 with predictions 1,0,1,1
    drive(1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
    #1; chk("fill0_idx", 32'(pred_index), 32'h4);
    step();
    drive(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
    #1; chk("fill1_idx", 32'(pred_index), 32'h5);
    step();
    drive(1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
    #1; chk("fill2_idx", 32'(pred_index), 32'h1);
    step();
    drive(1'b1, 4'h8, 1'b1, 1'b0, 1'b0);
    #1; chk("fill3_idx", 32'(pred_index), 32'h5);
    step();
    chk("full_count", 32'(count), 4);
    chk("full_ready", 32'(fetch_ready), 0);
    chk("full_spec", 32'(spec_ghr), 32'hB);

    // Fifth fetch is refused
    drive(1'b1, 4'h9, 1'b1, 1'b0, 1'b0);
    step();
    chk("over_count", 32'(count), 4);
    chk("over_spec", 32'(spec_ghr), 32'hB);

    // Full + resolve: fetch still refused, head (4,1) pops correctly
    drive(1'b1, 4'h9, 1'b1, 1'b1, 1'b1);
    #1; chk("full_ready_resolve", 32'(fetch_ready), 0);
    step();
    chk("pop1_count", 32'(count), 3);
    chk("pop1_pht_index", 32'(pht_index), 32'h4);
    chk("pop1_arch", 32'(arch_ghr), 32'h3);
    chk("pop1_spec", 32'(spec_ghr), 32'hB);

    // Simultaneous push (pc=A,pred=1 -> idx 1) and correct pop of (5,0)
    drive(1'b1, 4'hA, 1'b1, 1'b1, 1'b0);
    #1; chk("both_pred_index", 32'(pred_index), 32'h1);
    step();
    chk("both_count", 32'(count), 3);
    chk("both_spec", 32'(spec_ghr), 32'h7);
    chk("both_arch", 32'(arch_ghr), 32'h6);
    chk("both_pht_index", 32'(pht_index), 32'h5);
    chk("both_pht_last", 32'(pht_last_branch), 0);
    chk("both_mispredict", 32'(mispredict), 0);

    // Mispredict: head (1,1) resolves not-taken while a fetch is offered
    drive(1'b1, 4'h2, 1'b1, 1'b1, 1'b0);
    step();
    chk("mis_pulse", 32'(mispredict), 1);
    chk("mis_count", 32'(count), 0);
    chk("mis_spec", 32'(spec_ghr), 32'hC);
    chk("mis_arch", 32'(arch_ghr), 32'hC);
    chk("mis_pht_write", 32'(pht_write), 1);
    chk("mis_pht_index", 32'(pht_index), 32'h1);
    chk("recover_ready", 32'(fetch_ready), 0);

    // RECOVER: fetch and resolve are ignored
    drive(1'b1, 4'h2, 1'b1, 1'b1, 1'b1);
    step();
    chk("rec_mispredict", 32'(mispredict), 0);
    chk("rec_pht_write", 32'(pht_write), 0);
    chk("rec_count", 32'(count), 0);
    chk("rec_arch", 32'(arch_ghr), 32'hC);
    chk("run_ready", 32'(fetch_ready), 1);

    // Resolve on empty queue
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    step();
    chk("empty_pht_write", 32'(pht_write), 0);
    chk("empty_count", 32'(count), 0);
    chk("empty_arch", 32'(arch_ghr), 32'hC);
    chk("empty_spec", 32'(spec_ghr), 32'hC);

    // Second mispredict: push pred=0 (idx C), resolve taken
    drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    #1; chk("f5_pred_index", 32'(pred_index), 32'hC);
    step();
    chk("f5_spec", 32'(spec_ghr), 32'h8);
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    step();
    chk("mis2_pulse", 32'(mispredict), 1);
    chk("mis2_spec", 32'(spec_ghr), 32'h9);
    chk("mis2_arch", 32'(arch_ghr), 32'h9);
`ifdef BRQ_STATS_EN
    chk("stat_branches", 32'(stat_branches), 5);
    chk("stat_mispredicts", 32'(stat_mispredicts), 2);
`else
    chk("stat_branches", 32'(stat_branches), 0);
    chk("stat_mispredicts", 32'(stat_mispredicts), 0);
`endif

    // Reset while in RECOVER, with other activity presented
    rst = 1'b1;
    drive(1'b1, 4'h1, 1'b1, 1'b1, 1'b0);
    step();
    rst = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("rrst_mispredict", 32'(mispredict), 0);
    chk("rrst_pht_write", 32'(pht_write), 0);
    chk("rrst_pht_index", 32'(pht_index), 0);
    chk("rrst_pht_last", 32'(pht_last_branch), 0);
    chk("rrst_count", 32'(count), 0);
    chk("rrst_spec", 32'(spec_ghr), 0);
    chk("rrst_arch", 32'(arch_ghr), 0);
    chk("rrst_ready", 32'(fetch_ready), 1);
    chk("rrst_stat_br", 32'(stat_branches), 0);
    chk("rrst_stat_mis", 32'(stat_mispredicts), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
